// File: rtl/prog_mem_loader_if.sv
// rtl/prog_mem_loader_if.sv - host source/sink streams and memory port of the program memory loader
interface prog_mem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic [DATA_W-1:0]   src_data;
    logic                src_valid;
    logic                src_ready;
    logic [DATA_W-1:0]   snk_data;
    logic                snk_valid;
    logic                snk_ready;
    logic                mem_en;
    logic [DATA_W/8-1:0] mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_din;
    logic [DATA_W-1:0]   mem_dout;
    logic                mem_sel;

    modport master (
        input  src_data, src_valid, snk_ready, mem_dout,
        output src_ready, snk_data, snk_valid, mem_en, mem_we, mem_addr, mem_din, mem_sel
    );

    modport slave (
        output src_data, src_valid, snk_ready, mem_dout,
        input  src_ready, snk_data, snk_valid, mem_en, mem_we, mem_addr, mem_din, mem_sel
    );
endinterface

// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - writes, reads back or verifies a single-port program memory from host streams
module prog_mem_loader #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int unsigned       MEM_BYTES = 32'h8000,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ERR_W     = 16
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] len_words,
    input  logic              abort,
    prog_mem_loader_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr
);
    localparam int unsigned       BYTES   = DATA_W / 8;
    localparam int unsigned       DEPTH   = MEM_BYTES / BYTES;
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, WRITE, RD_ISSUE, RD_CAP, RD_OUT, VF_ISSUE, VF_CMP, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
    logic [DATA_W-1:0] snk_data_q, snk_data_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              snk_valid_q, snk_valid_d;
    logic              aborted_q, aborted_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic [ADDR_W-1:0] len_eff;
    logic              last_word;

    // Out-of-range lengths collapse to a full-memory pass, so the address can never wrap.
    assign len_eff   = (len_words == '0 || len_words > DEPTH_A) ? DEPTH_A : len_words;
    assign last_word = (cnt_q == ADDR_W'(1));

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            cnt_q            <= '0;
            first_err_addr_q <= '0;
            snk_data_q       <= '0;
            exp_q            <= '0;
            snk_valid_q      <= 1'b0;
            aborted_q        <= 1'b0;
            err_count_q      <= '0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            cnt_q            <= cnt_d;
            first_err_addr_q <= first_err_addr_d;
            snk_data_q       <= snk_data_d;
            exp_q            <= exp_d;
            snk_valid_q      <= snk_valid_d;
            aborted_q        <= aborted_d;
            err_count_q      <= err_count_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        cnt_d            = cnt_q;
        first_err_addr_d = first_err_addr_q;
        snk_data_d       = snk_data_q;
        exp_d            = exp_q;
        snk_valid_d      = snk_valid_q;
        aborted_d        = aborted_q;
        err_count_d      = err_count_q;
        bus.src_ready    = 1'b0;
        bus.mem_en       = 1'b0;
        bus.mem_we       = '0;
        bus.mem_din      = '0;

        case (state_q)
            IDLE: begin
                if (start && mode != 2'd0) begin
                    addr_d           = BASE_ADDR;
                    cnt_d            = len_eff;
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                    aborted_d        = 1'b0;
                    case (mode)
                        2'd1:    state_d = WRITE;
                        2'd2:    state_d = RD_ISSUE;
                        default: state_d = VF_ISSUE;
                    endcase
                end
            end
            WRITE: begin
                bus.src_ready = 1'b1;
                if (bus.src_valid) begin
                    bus.mem_en  = 1'b1;
                    bus.mem_we  = '1;
                    bus.mem_din = bus.src_data;
                    cnt_d       = cnt_q - ADDR_W'(1);
                    if (last_word) state_d = DONE;
                    else           addr_d  = addr_q + STEP;
                end
            end
            RD_ISSUE: begin
                bus.mem_en = 1'b1;
                state_d    = RD_CAP;
            end
            RD_CAP: begin
                snk_data_d  = bus.mem_dout;
                snk_valid_d = 1'b1;
                state_d     = RD_OUT;
            end
            RD_OUT: begin
                if (bus.snk_ready) begin
                    snk_valid_d = 1'b0;
                    cnt_d       = cnt_q - ADDR_W'(1);
                    if (last_word) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + STEP;
                        state_d = RD_ISSUE;
                    end
                end
            end
            VF_ISSUE: begin
                bus.src_ready = 1'b1;
                if (bus.src_valid) begin
                    bus.mem_en = 1'b1;
                    exp_d      = bus.src_data;
                    state_d    = VF_CMP;
                end
            end
            VF_CMP: begin
                if (bus.mem_dout != exp_q) begin
                    // err_count only ever leaves zero upward and saturates, so zero means no mismatch yet.
                    if (err_count_q == '0)  first_err_addr_d = addr_q;
                    if (err_count_q != '1)  err_count_d      = err_count_q + ERR_W'(1);
                end
                cnt_d = cnt_q - ADDR_W'(1);
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + STEP;
                    state_d = VF_ISSUE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d     = IDLE;
            aborted_d   = 1'b1;
            snk_valid_d = 1'b0;
        end
    end

    assign busy           = (state_q != IDLE) && (state_q != DONE);
    assign done           = (state_q == DONE) && !abort;
    assign aborted        = aborted_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign bus.mem_sel    = busy;
    assign bus.mem_addr   = addr_q;
    assign bus.snk_data   = snk_data_q;
    assign bus.snk_valid  = snk_valid_q;
endmodule
